// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and the entry layout for the instruction
// fetch queue. Optional statistics are enabled with FETCH_QUEUE_STATS_EN.
package fetch_queue_pkg;

   localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
   localparam int          ENTRY_W       = 64;
   localparam int          INSTR_LSB     = 0;
   localparam int          PC_PLUS4_LSB  = 32;

   // One queued fetch: PC+4 in the upper word, instruction in the lower word.
   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } fq_entry_t;

   // Builds a queue entry from the PC it was fetched at and its instruction.
   function automatic fq_entry_t make_entry(input logic [31:0] pc,
                                            input logic [31:0] instr);
      fq_entry_t e;
      e.pc_plus4 = pc + 32'd4;
      e.instr    = instr;
      return e;
   endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x 64-bit register array with one synchronous write
// port and one combinational read port. Holds no control state.
module fetch_queue_mem
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [ENTRY_W-1:0] rdata
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   // Write port: store the entry on the rising edge when enabled.
   // NOTE: storage has no reset; validity is tracked by the pointers and
   // count, so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order buffer of {PC+4, instruction} pairs between fetch and
// decode. Stalls the PC when full, drops everything on a taken branch/jump.
// Define FETCH_QUEUE_STATS_EN to add stall and flush cycle counters.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [31:0]   pc_i,
   input  logic [31:0]   instr_i,
   input  logic          flush_i,
   input  logic          id_ready_i,
   output logic          id_valid_o,
   output logic [31:0]   id_instr_o,
   output logic [31:0]   id_pc_plus4_o,
   output logic          pc_write_o,
`ifdef FETCH_QUEUE_STATS_EN
   output logic [31:0]   stall_cnt_o,
   output logic [31:0]   flush_cnt_o,
`endif
   output logic [CW-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   fq_entry_t     wr_entry;
   fq_entry_t     rd_entry;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign push     = !flush_i && !full;
   assign pop      = !empty && id_ready_i && !flush_i;
   assign wr_entry = make_entry(pc_i, instr_i);

   fetch_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk_i (clk_i),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   // Pointer and occupancy update; reset and flush both empty the queue.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head-of-queue presentation to decode, forced to NOP/0 when empty.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      id_valid_o    = 1'b0;
      id_instr_o    = NOP_INSTR;
      id_pc_plus4_o = 32'h0;
      if (!empty) begin
         id_valid_o    = 1'b1;
         id_instr_o    = rd_entry.instr;
         id_pc_plus4_o = rd_entry.pc_plus4;
      end
   end

   // Flush always lets the PC load the target; otherwise stall only when full.
   assign pc_write_o = flush_i || !full;
   assign count_o    = count;

`ifdef FETCH_QUEUE_STATS_EN
   // Free-running wrap-around counters of stall cycles and flush cycles.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= 32'h0;
         flush_cnt_o <= 32'h0;
      end else begin
         if (!pc_write_o) stall_cnt_o <= stall_cnt_o + 32'd1;
         if (flush_i)     flush_cnt_o <= flush_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus for fetch_queue, checked every
// cycle against a queue-based reference model of the fetch/decode buffer.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   typedef struct {
      logic [31:0] pc4;
      logic [31:0] instr;
   } ref_t;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [31:0]   pc_i = 32'h0;
   logic [31:0]   instr_i = 32'h0;
   logic          flush_i = 1'b0;
   logic          id_ready_i = 1'b0;
   logic          id_valid_o;
   logic [31:0]   id_instr_o;
   logic [31:0]   id_pc_plus4_o;
   logic          pc_write_o;
   logic [CW-1:0] count_o;
`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0]   stall_cnt_o;
   logic [31:0]   flush_cnt_o;
   logic [31:0]   m_stall = 32'h0;
   logic [31:0]   m_flush = 32'h0;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   ref_t model_q[$];
   logic [31:0] pc_run = 32'h0;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .pc_i          (pc_i),
      .instr_i       (instr_i),
      .flush_i       (flush_i),
      .id_ready_i    (id_ready_i),
      .id_valid_o    (id_valid_o),
      .id_instr_o    (id_instr_o),
      .id_pc_plus4_o (id_pc_plus4_o),
      .pc_write_o    (pc_write_o),
`ifdef FETCH_QUEUE_STATS_EN
      .stall_cnt_o   (stall_cnt_o),
      .flush_cnt_o   (flush_cnt_o),
`endif
      .count_o       (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every output with the model, then advance DUT and model one cycle.
   task automatic cycle(input logic r, input logic f, input logic rdy,
                        input logic [31:0] pc, input logic [31:0] ins);
      int   sz;
      ref_t e;
      logic exp_pcw;
      rst_i = r; flush_i = f; id_ready_i = rdy; pc_i = pc; instr_i = ins;
      #1;
      sz      = model_q.size();
      exp_pcw = f || (sz != DEPTH);
      check("id_valid", 32'(id_valid_o), 32'(sz != 0));
      check("id_instr", id_instr_o, (sz != 0) ? model_q[0].instr : 32'h0);
      check("id_pc_plus4", id_pc_plus4_o, (sz != 0) ? model_q[0].pc4 : 32'h0);
      check("count", 32'(count_o), 32'(sz));
      check("pc_write", 32'(pc_write_o), 32'(exp_pcw));
`ifdef FETCH_QUEUE_STATS_EN
      check("stall_cnt", stall_cnt_o, m_stall);
      check("flush_cnt", flush_cnt_o, m_flush);
`endif
      @(posedge clk_i);
      if (r || f) begin
         model_q.delete();
      end else begin
         if (sz != 0 && rdy) void'(model_q.pop_front());
         if (sz != DEPTH) begin
            e.pc4   = pc + 32'd4;
            e.instr = ins;
            model_q.push_back(e);
         end
      end
`ifdef FETCH_QUEUE_STATS_EN
      if (r) begin
         m_stall = 32'h0;
         m_flush = 32'h0;
      end else begin
         if (!exp_pcw) m_stall = m_stall + 32'd1;
         if (f)        m_flush = m_flush + 32'd1;
      end
`endif
      @(negedge clk_i);
   endtask

   // Sequential fetch from pc_run: PC advances only when the model lets it write.
   task automatic fetch(input logic f, input logic rdy, input logic [31:0] target);
      logic [31:0] pc_now;
      logic        adv;
      pc_now = pc_run;
      adv    = f || (model_q.size() != DEPTH);
      cycle(1'b0, f, rdy, pc_now, 32'hC0DE_0000 ^ pc_now);
      if (f)        pc_run = target;
      else if (adv) pc_run = pc_now + 32'd4;
   endtask

   initial begin
      // Bring the DUT out of an unknown state before any comparison.
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);

      // Reset cycle, then consecutive fetches with decode always ready.
      cycle(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'hA);
      cycle(1'b0, 1'b0, 1'b1, 32'h4, 32'hB);
      cycle(1'b0, 1'b0, 1'b1, 32'h8, 32'hC);
      cycle(1'b0, 1'b0, 1'b1, 32'hC, 32'hD);
      pc_run = 32'h10;

      // Decode stalls for six cycles: fill to DEPTH, PC stalls.
      repeat (6) fetch(1'b0, 1'b0, 32'h0);
      // One ready cycle while full, then hold, then drain under ready.
      fetch(1'b0, 1'b1, 32'h0);
      fetch(1'b0, 1'b0, 32'h0);
      repeat (8) fetch(1'b0, 1'b1, 32'h0);

      // Three entries queued, then flush with decode ready; recover at target.
      fetch(1'b1, 1'b0, 32'h0000_0400);
      repeat (3) fetch(1'b0, 1'b0, 32'h0);
      fetch(1'b1, 1'b1, 32'h0000_0800);
      repeat (3) fetch(1'b0, 1'b1, 32'h0);

      // PC+4 wraps at the top of the address space.
      cycle(1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
      cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h9ABC_DEF0);
      pc_run = 32'h4;

      // Reset with two entries queued; next cycle shows reset values.
      fetch(1'b1, 1'b0, 32'h0000_0100);
      repeat (2) fetch(1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b1, pc_run, 32'hDEAD_BEEF);
      rst_i = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
      #1;
      check("rst_valid", 32'(id_valid_o), 32'h0);
      check("rst_instr", id_instr_o, 32'h0);
      check("rst_pc4", id_pc_plus4_o, 32'h0);
      check("rst_count", 32'(count_o), 32'h0);
      check("rst_pc_write", 32'(pc_write_o), 32'h1);
`ifdef FETCH_QUEUE_STATS_EN
      check("rst_stall_cnt", stall_cnt_o, 32'h0);
      check("rst_flush_cnt", flush_cnt_o, 32'h0);
`endif
      pc_run = 32'h0000_2000;

      // Random traffic: ready ~70%, flush ~6%, reset ~2%.
      for (int i = 0; i < 400; i++) begin
         logic rdy, f, r;
         rdy = ($urandom_range(0, 9) < 7);
         f   = ($urandom_range(0, 99) < 6);
         r   = ($urandom_range(0, 99) < 2);
         if (r) begin
            cycle(1'b1, f, rdy, pc_run, $urandom);
         end else begin
            fetch(f, rdy, {$urandom_range(0, 16'hFFFF), 16'h0});
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
